// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: bursts words from NUM_CH upstream FIFOs into one
// valid/ready stream through a 2-entry tagged output buffer.
module fifo_rr_scheduler #(
    parameter int unsigned DATA_BIT  = 64,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_BIT    = $clog2(NUM_CH),
    parameter int unsigned BURST_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_rempty,
    output logic [NUM_CH-1:0]            ch_ren,
    input  logic [NUM_CH*DATA_BIT-1:0]   ch_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_BIT-1:0]          out_data,
    output logic [CH_BIT-1:0]            out_ch,
    output logic                         busy
);

    localparam int unsigned BEAT_BIT = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [CH_BIT-1:0]     grant;
    logic [CH_BIT-1:0]     last_grant;
    logic [BEAT_BIT-1:0]   beat_cnt;
    logic                  inflight;
    logic [CH_BIT-1:0]     inflight_ch;
    logic [DATA_BIT-1:0]   buf_data [2];
    logic [CH_BIT-1:0]     buf_ch   [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_cnt;

    logic [DATA_BIT-1:0]   rdata_arr [NUM_CH];
    logic                  pop;
    logic [2:0]            credit_sum;
    logic                  credit_ok;
    logic                  ren_fire;
    logic                  last_beat;
    logic                  burst_done;
    logic                  found;
    logic [CH_BIT-1:0]     pick;
    int unsigned           idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign rdata_arr[i] = ch_rdata[i*DATA_BIT +: DATA_BIT];
    end

    // Credit counts buffered words plus the one in flight, net of this cycle's pop.
    assign pop        = out_valid & out_ready;
    assign credit_sum = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign credit_ok  = credit_sum < 3'd2;
    assign ren_fire   = (state == BURST) & ~ch_rempty[grant] & credit_ok;
    assign last_beat  = beat_cnt == BEAT_BIT'(BURST_MAX - 1);
    assign burst_done = (ren_fire & last_beat) | (ch_rempty[grant] & credit_ok);
    assign ch_ren     = ren_fire ? (NUM_CH'(1) << grant) : '0;

    assign out_valid  = buf_cnt != 2'd0;
    assign out_data   = buf_data[rd_ptr];
    assign out_ch     = buf_ch[rd_ptr];
    assign busy       = (state == BURST) | inflight | (buf_cnt != 2'd0);

    // First non-empty channel after last_grant, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(last_grant) + k) % NUM_CH;
            if (!found && !ch_rempty[CH_BIT'(idx)]) begin
                found = 1'b1;
                pick  = CH_BIT'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_BIT'(NUM_CH - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (ren_fire) begin
                        beat_cnt <= beat_cnt + BEAT_BIT'(1);
                    end
                    if (burst_done) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the word one cycle after its ren, into the tagged output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_ch <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_cnt     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_ch[i]   <= '0;
            end
        end else begin
            inflight    <= ren_fire;
            inflight_ch <= grant;
            if (inflight) begin
                buf_data[wr_ptr] <= rdata_arr[inflight_ch];
                buf_ch[wr_ptr]   <= inflight_ch;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_cnt <= buf_cnt + 2'(inflight) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural upstream FIFOs, a round-robin
// reference model feeding an expected-output queue, and per-scenario checks.
module tb_fifo_rr_scheduler;

    localparam int unsigned DATA_BIT = 64;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_BIT   = 2;
    localparam int unsigned BMAX     = 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_CH-1:0]          ch_rempty;
    logic [NUM_CH-1:0]          ch_ren;
    logic [NUM_CH*DATA_BIT-1:0] ch_rdata;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [DATA_BIT-1:0]        out_data;
    logic [CH_BIT-1:0]          out_ch;
    logic                       busy;

    int checks   = 0;
    int failures = 0;

    // Upstream FIFO model: writer side owned by the stimulus, reader side by the clock.
    logic [DATA_BIT-1:0] mem [NUM_CH][256];
    logic [DATA_BIT-1:0] rdata_q [NUM_CH];
    int unsigned         wr_cnt [NUM_CH] = '{default: 0};
    int unsigned         rd_cnt [NUM_CH] = '{default: 0};
    int unsigned         model_rd [NUM_CH] = '{default: 0};
    int                  model_last = NUM_CH - 1;
    int unsigned         gid = 0;

    logic [CH_BIT+DATA_BIT-1:0] sb [$];

    always #5 clk = ~clk;

    fifo_rr_scheduler #(
        .DATA_BIT (DATA_BIT),
        .NUM_CH   (NUM_CH),
        .CH_BIT   (CH_BIT),
        .BURST_MAX(BMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_rempty(ch_rempty),
        .ch_ren   (ch_ren),
        .ch_rdata (ch_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .busy     (busy)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        assign ch_rempty[i] = (wr_cnt[i] == rd_cnt[i]);
        assign ch_rdata[i*DATA_BIT +: DATA_BIT] = rdata_q[i];
        initial rdata_q[i] = '0;
        always @(posedge clk) begin
            if (ch_ren[i] && (wr_cnt[i] != rd_cnt[i])) begin
                rdata_q[i] <= mem[i][8'(rd_cnt[i])];
                rd_cnt[i]  <= rd_cnt[i] + 1;
            end
        end
    end

    // Output monitor and safety invariants.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (((ch_ren & (ch_ren - 4'd1)) != 4'd0) || ((ch_ren & ch_rempty) != 4'd0)) begin
                failures++;
                $display("FAIL ren_safety: ch_ren=%b ch_rempty=%b", ch_ren, ch_rempty);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got ch=%0d data=%h, none expected", out_ch, out_data);
                end else begin
                    logic [CH_BIT+DATA_BIT-1:0] exp_e;
                    exp_e = sb.pop_front();
                    if ({out_ch, out_data} !== exp_e) begin
                        failures++;
                        $display("FAIL stream_word: got ch=%0d data=%h, expected ch=%0d data=%h",
                                 out_ch, out_data, exp_e[CH_BIT+DATA_BIT-1:DATA_BIT], exp_e[DATA_BIT-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int ch, input logic [DATA_BIT-1:0] val);
        mem[2'(ch)][8'(wr_cnt[2'(ch)])] = val;
        wr_cnt[2'(ch)] = wr_cnt[2'(ch)] + 1;
    endtask

    task automatic expect_words(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({2'(ch), mem[2'(ch)][8'(model_rd[2'(ch)])]});
            model_rd[2'(ch)] = model_rd[2'(ch)] + 1;
        end
    endtask

    // Load all channels at once and queue the expected round-robin output order.
    task automatic load_rr(input int n0, input int n1, input int n2, input int n3);
        int n [4];
        int g;
        int c;
        int take;
        n = '{n0, n1, n2, n3};
        for (int ch = 0; ch < 4; ch++) begin
            for (int k = 0; k < n[ch]; k++) begin
                gid++;
                push_word(ch, {8'hD0, 8'(ch), 16'h0, 32'(gid)});
            end
        end
        while (1) begin
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                c = (model_last + k) % 4;
                if (g < 0 && n[c] > 0) g = c;
            end
            if (g < 0) break;
            take = (n[g] > int'(BMAX)) ? int'(BMAX) : n[g];
            expect_words(g, take);
            n[g] -= take;
            model_last = g;
        end
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 500; i++) begin
            if (sb.size() == 0 && !busy && ch_rempty == 4'hF) break;
            tick();
        end
        checks++;
        if (i >= 500 || sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d expected words left, busy=%b", name, sb.size(), busy);
        end
    endtask

    // Leave last_grant at channel 3 so the next round starts from channel 0.
    task automatic prime_last3();
        load_rr(0, 0, 0, 1);
        wait_drain("prime");
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({ch_ren, out_valid, out_data, out_ch, busy} !== '0) begin
            failures++;
            $display("FAIL reset_values: ren=%b valid=%b data=%h ch=%0d busy=%b, expected all 0",
                     ch_ren, out_valid, out_data, out_ch, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) push_word(1, 64'hBAD0_0000 + 64'(k));
        repeat (6) tick();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill: valid=%b busy=%b, expected 1 1", out_valid, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ch_ren !== 4'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midburst: valid=%b ren=%b busy=%b, expected 0 0 0", out_valid, ch_ren, busy);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            wr_cnt[2'(i)]   = rd_cnt[2'(i)];
            model_rd[2'(i)] = rd_cnt[2'(i)];
        end
        model_last = NUM_CH - 1;
        rst = 1'b0;
        out_ready = 1'b1;
        load_rr(1, 0, 1, 0);
        tick();
        checks++;
        if (ch_ren !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant: ren=%b, expected 0001", ch_ren);
        end
        wait_drain("reset");
    endtask

    task automatic test_single();
        logic [3:0]          e_ren [6];
        logic                e_val [6];
        logic [DATA_BIT-1:0] e_dat [6];
        e_ren = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        e_val = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e_dat = '{64'h0, 64'h0, 64'hA, 64'hB, 64'hC, 64'h0};
        out_ready = 1'b1;
        push_word(2, 64'hA);
        push_word(2, 64'hB);
        push_word(2, 64'hC);
        expect_words(2, 3);
        model_last = 2;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ch_ren !== e_ren[i] || out_valid !== e_val[i]) begin
                failures++;
                $display("FAIL single_cycle%0d: ren=%b valid=%b, expected ren=%b valid=%b",
                         i, ch_ren, out_valid, e_ren[i], e_val[i]);
            end
            if (e_val[i]) begin
                checks++;
                if (out_data !== e_dat[i] || out_ch !== 2'd2) begin
                    failures++;
                    $display("FAIL single_data%0d: data=%h ch=%0d, expected data=%h ch=2",
                             i, out_data, out_ch, e_dat[i]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%b, expected 0", busy);
        end
        wait_drain("single");
    endtask

    task automatic test_round_robin();
        prime_last3();
        out_ready = 1'b1;
        load_rr(20, 20, 20, 20);
        wait_drain("round_robin");
    endtask

    task automatic test_early_term();
        prime_last3();
        out_ready = 1'b1;
        load_rr(0, 3, 0, 10);
        wait_drain("early_term");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        load_rr(12, 0, 0, 0);
        repeat (5) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b ch=%0d data=%h, expected held head", i, out_valid, out_ch, out_data);
            end
            if (i > 0) begin
                checks++;
                if (ch_ren !== 4'b0) begin
                    failures++;
                    $display("FAIL bp_ren%0d: ren=%b, expected 0000", i, ch_ren);
                end
            end
        end
        out_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_refill();
        int i;
        prime_last3();
        out_ready = 1'b1;
        load_rr(2, 6, 0, 0);
        for (i = 0; i < 20; i++) begin
            if (ch_ren[1]) break;
            tick();
        end
        checks++;
        if (i >= 20) begin
            failures++;
            $display("FAIL refill_grant1: ren=%b, expected ch1 read within 20 cycles", ch_ren);
        end
        gid++;
        push_word(0, {8'hE0, 8'h00, 16'h0, 32'(gid)});
        expect_words(0, 1);
        model_last = 0;
        wait_drain("refill");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_term();
        test_backpressure();
        test_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin read scheduler that shares one downstream valid/ready stream among `NUM_CH` upstream `sync_fifo` instances on the same clock. It watches each FIFO's `rempty` and drives the per-channel `ren`. It grants one channel at a time for a burst of up to `BURST_MAX` words. Returned `rdata` lands in a 2-entry output buffer, tagged with its channel number. The block sits between the per-requester FIFOs and a single consumer, for example a DMA write port or a compute-array input.

## Interface
- `DATA_BIT`, 64, word width; matches the upstream FIFOs.
- `NUM_CH`, 4, number of upstream FIFOs; must be at least 2.
- `CH_BIT`, `$clog2(NUM_CH)`, width of the channel tag.
- `BURST_MAX`, 8, maximum words read per grant; must be at least 1.
- `clk`  in  1  single clock, shared with all upstream FIFOs.
- `rst`  in  1  asynchronous, active-high reset.
- `ch_rempty`  in  `NUM_CH`  per-channel empty flags from the FIFOs.
- `ch_ren`  out  `NUM_CH`  per-channel read enables; at most one bit high at a time.
- `ch_rdata`  in  `NUM_CH*DATA_BIT`  concatenated FIFO read data; channel i occupies bits `[i*DATA_BIT +: DATA_BIT]`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  `DATA_BIT`  output word.
- `out_ch`  out  `CH_BIT`  source channel of `out_data`.
- `busy`  out  1  high in BURST, or while any read is in flight or buffered.

## Operation
- **Upstream read contract:** `ch_ren[i]` high in cycle T makes the FIFO present the word on `ch_rdata[i]` in cycle T+1. The scheduler captures that word at the end of T+1.
- **FSM states:** IDLE and BURST.
- **IDLE:**
  - Search from `last_grant+1`, modulo `NUM_CH`, for the first channel with `ch_rempty` low.
  - If one is found, register it as `grant`, clear `beat_cnt`, and move to BURST.
  - Otherwise stay in IDLE.
  - IDLE never asserts `ch_ren`.
- **BURST:**
  - Drive `ch_ren[grant] = ~ch_rempty[grant] & credit_ok`.
  - `credit_ok = (buf_cnt + inflight - pop) < 2`, where `pop = out_valid & out_ready`.
  - `inflight` is 1 if `ren` was high in the previous cycle.
  - Every asserted `ren` increments `beat_cnt`.
- **BURST exit:** go to IDLE and set `last_grant <= grant` when either condition holds:
  - `ren` fires with `beat_cnt == BURST_MAX-1`.
  - `ch_rempty[grant]` is high while `credit_ok` is high, so the burst ends early.
- **Stall while empty:** if `ch_rempty[grant]` is high and `credit_ok` is low, stay in BURST. The decision is deferred until credit returns.
- **Other channels:** `ch_rempty` of non-granted channels is ignored during BURST.
- **Output buffer:** a 2-entry FIFO of `{ch, data}`.
  - `out_valid = buf_cnt != 0`.
  - `out_data`/`out_ch` show the head entry.
  - Push and pop in the same cycle are allowed.
  - Overflow is impossible by the credit rule.
- **Ordering:**
  - Words from one channel leave in FIFO order.
  - Words from consecutive bursts are never interleaved.
- **`last_grant` reset value:** `NUM_CH-1`, so channel 0 has first priority after reset.
- **Reset values (asynchronous):**
  - `ch_ren = 0`, `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `busy = 0`.
  - State IDLE, `buf_cnt = 0`, `inflight = 0`, `beat_cnt = 0`.
- **Reset mid-operation:** buffered and in-flight words are discarded. FIFO recovery is the system's responsibility, since the FIFOs share `rst`.

## Timing
- **Arbitration:** one cycle. `ch_rempty[i]` sampled low at edge t gives BURST from t+1, and first `ren` at t+1.
- **Latency:** first `out_valid` at t+3, i.e. `ren`, then data capture, then buffer head.
- **Throughput:** with `out_ready` held high, one word per cycle within a burst.
- **Burst gap:** one IDLE cycle between bursts, plus re-fill latency.
- **Backpressure:**
  - With `out_ready` low, at most 2 words are held.
  - `ren` stops within 1 cycle.
  - `out_data`/`out_ch` stay stable while `out_valid & ~out_ready`.
- **Safety invariants:**
  - `ch_ren[i]` is never high while `ch_rempty[i]` is high.
  - `ch_ren` is never high for more than one channel at a time.

## Test plan
- **Reset:** assert `rst` mid-burst with 2 words buffered → within the same cycle `out_valid = 0`, `ch_ren = 0`, `busy = 0`; after release the first grant goes to channel 0 if it is non-empty.
- **Single channel:** ch2 holds `64'hA`, `64'hB`, `64'hC`; `out_ready = 1` → `ch_ren[2]` high 3 consecutive cycles; output A, B, C back-to-back with `out_ch = 2`; first `out_valid` 3 cycles after the IDLE sample; then IDLE.
- **Round robin:** all 4 channels hold 20 words each, `BURST_MAX = 8` → `out_ch` sequence 0×8, 1×8, 2×8, 3×8, 0×8, 1×8, 2×8, 3×8, 0×4, 1×4, 2×4, 3×4; per-channel values in order, none lost.
- **Early termination:** ch1 holds 3 words, ch3 holds 10 → ch1×3, ch3×8, ch3×2; no `ren` issued to an empty FIFO.
- **Backpressure:** drop `out_ready` for 5 cycles mid-burst → `buf_cnt` saturates at 2; `ren` stays low; `out_data` stays stable; after release the stream resumes with no gap, duplicate or loss.
- **Refill during IDLE:** ch0 empties, ends its burst, then gets 1 word pushed while ch1 is granted → ch0 is served in the next round, not pre-empting ch1.
